priority_encoder_8_to_3: RTL

Registered 8-to-3 priority encoder with request capture and a valid/ack handshake. It is the encoding counterpart of the 3-to-8 decoder: eight request lines in, one 3-bit code out. Rising edges on the request lines are latched as pending; the FSM presents one code at a time and holds it until the consumer acknowledges it. It sits between interrupt/event sources and a single consumer that decodes the returned code.

---
 rtl/priority_encoder_8_to_3.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/priority_encoder_8_to_3.sv
// Registered 8-to-3 priority encoder: rising edges on d are captured as pending and granted one at a time over a valid/ack handshake.
// Define PRIORITY_ENCODER_RR_EN for round-robin selection; the default build uses fixed highest-index priority.
module priority_encoder_8_to_3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    input  logic       en,
    input  logic       ack,
    output logic [2:0] a,
    output logic       valid,
    output logic [7:0] pend,
    output logic       ovf
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [7:0] r_dPrev;
    logic [7:0] r_pend;
    logic [2:0] r_a;
    logic       r_valid;
    logic       r_ovf;

    logic [7:0] w_edge;
    logic [7:0] w_clr;
    logic [7:0] w_pendNext;
    logic       w_ovfNext;
    logic       w_grant;
    logic [2:0] w_sel;
    logic [2:0] w_aNext;
    logic       w_validNext;

    // An ack clears the granted bit, but a new edge on that same bit in the same cycle re-sets it.
    always_comb begin
        w_edge = d & ~r_dPrev;
        w_clr  = 8'h00;
        if ((r_state == S_VALID) && ack) begin
            w_clr[r_a] = 1'b1;
        end
        w_pendNext = r_pend & ~w_clr;
        if (en) begin
            w_pendNext = w_pendNext | w_edge;
        end
        w_ovfNext = en & (|(w_edge & r_pend & ~w_clr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dPrev <= 8'h00;
            r_pend  <= 8'h00;
            r_ovf   <= 1'b0;
        end else begin
            r_dPrev <= d;
            r_pend  <= w_pendNext;
            r_ovf   <= w_ovfNext;
        end
    end

`ifdef PRIORITY_ENCODER_RR_EN
    logic [2:0] r_last;
    logic [2:0] w_idx;

    // Scan offsets from far to near so the nearest set bit after the last grant is written last.
    always_comb begin
        w_sel = 3'd0;
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            w_idx = r_last + 3'd1 + i[2:0];
            if (r_pend[w_idx]) begin
                w_sel = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 3'd7;
        end else if (w_grant) begin
            r_last <= w_sel;
        end
    end
`else
    always_comb begin
        w_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_pend[i]) begin
                w_sel = i[2:0];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_a     <= w_aNext;
            r_valid <= w_validNext;
        end
    end

    always_comb begin
        w_grant     = 1'b0;
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (en && (|r_pend)) begin
                    w_grant     = 1'b1;
                    w_stateNext = S_VALID;
                end
            end
            S_VALID: begin
                if (ack) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // The code is held for the whole VALID phase; only a fresh grant loads a new one.
    always_comb begin
        w_aNext     = r_a;
        w_validNext = (w_stateNext == S_VALID);
        if (w_grant) begin
            w_aNext = w_sel;
        end
    end

    assign a     = r_a;
    assign valid = r_valid;
    assign pend  = r_pend;
    assign ovf   = r_ovf;

endmodule
